pcm_serializer: RTL and testbench

// - Consumer end of the fir sample stream: accepts in_valid/in_sample words (no backpressure) and

---
 rtl/fir_pkg.sv | 14 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/pcm_serializer.sv | 170 +++++++++++++++++
 tb/tb_pcm_serializer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: constants and types shared by the fir sample-stream blocks.
//   SAMPLE_BITS_DEF : default sample word width
//   ser_state_t     : serializer link state (IDLE / ACTIVE / DRAIN)
package fir_pkg;

  localparam int unsigned SAMPLE_BITS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst        : clock, asynchronous active-high reset (pointers only)
//   wr_en, wr_data  : write request; accepted when not full, or full with a read in the same cycle
//   rd_en, rd_data  : rd_data always shows the head word; rd_en consumes it
//   full, empty     : occupancy == DEPTH / == 0
//   level           : current occupancy
// Pointers carry one extra MSB so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (level == FULL_LVL);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is legal when the head is read in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pcm_serializer.sv
// pcm_serializer: buffers fir output samples and sends them MSB-first on a 3-wire link.
//   clk, rst             : clock, asynchronous active-high reset
//   enable               : 1 = run link; 0 = finish current frame, then idle
//   clr_flags            : synchronous clear of overflow/underflow (a set event wins)
//   in_valid, in_sample  : fire-and-forget sample input
//   ser_bclk/sync/data   : bit clock, frame sync (MSB period), serial data
//   fifo_level           : FIFO occupancy
//   overflow, underflow  : sticky drop / empty-frame flags
module pcm_serializer
  import fir_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned BCLK_DIV    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        clr_flags,
  input  logic                        in_valid,
  input  logic [SAMPLE_BITS-1:0]      in_sample,
  output logic                        ser_bclk,
  output logic                        ser_sync,
  output logic                        ser_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BW = $clog2(SAMPLE_BITS);
  localparam logic [DW-1:0] DIV_TC   = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SAMPLE_BITS - 1);

  ser_state_t             state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic                   bclk_q, bclk_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic                   sync_q, sync_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   ovf_q, ovf_d;
  logic                   ufl_q, ufl_d;

  logic                   pop, ufl_set, ovf_set, div_tc, strobe;
  logic                   fifo_full, fifo_empty, fifo_wr;
  logic [SAMPLE_BITS-1:0] fifo_rd_data;

  assign fifo_wr = in_valid && (!fifo_full || pop);
  assign ovf_set = in_valid && fifo_full && !pop;

  sync_fifo #(
    .WIDTH(SAMPLE_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (fifo_wr),
    .wr_data(in_sample),
    .rd_en  (pop),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign div_tc = (div_q == DIV_TC);
  // Falling edge of the bit clock: the only point where data/sync advance.
  assign strobe = (state_q != IDLE) && div_tc && bclk_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bclk_d  = bclk_q;
    shift_d = shift_q;
    sync_d  = sync_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    ufl_set = 1'b0;
    case (state_q)
      IDLE: begin
        div_d  = '0;
        bclk_d = 1'b0;
        if (enable && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          sync_d  = 1'b1;
          bit_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE, DRAIN: begin
        if (div_tc) begin
          div_d  = '0;
          bclk_d = !bclk_q;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (strobe) begin
          if (state_q == DRAIN) begin
            shift_d = '0;
            sync_d  = 1'b0;
            bit_d   = '0;
            state_d = IDLE;
          end else if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (!enable) begin
              // Register is fully shifted out here, so DRAIN idles the line at 0.
              shift_d = shift_q << 1;
              sync_d  = 1'b0;
              state_d = DRAIN;
            end else if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_rd_data;
              sync_d  = 1'b1;
            end else begin
              shift_d = '0;
              sync_d  = 1'b1;
              ufl_set = 1'b1;
            end
          end else begin
            shift_d = shift_q << 1;
            sync_d  = 1'b0;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    ufl_d = ufl_q;
    if (clr_flags) begin
      ovf_d = 1'b0;
      ufl_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (ufl_set) ufl_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bclk_q  <= 1'b0;
      shift_q <= '0;
      sync_q  <= 1'b0;
      bit_q   <= '0;
      ovf_q   <= 1'b0;
      ufl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      shift_q <= shift_d;
      sync_q  <= sync_d;
      bit_q   <= bit_d;
      ovf_q   <= ovf_d;
      ufl_q   <= ufl_d;
    end
  end

  assign ser_bclk  = bclk_q;
  assign ser_sync  = sync_q;
  assign ser_data  = shift_q[SAMPLE_BITS-1];
  assign overflow  = ovf_q;
  assign underflow = ufl_q;

endmodule

// File: tb/tb_pcm_serializer.sv
module tb_pcm_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clr_flags = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_sample = '0;
  logic        ser_bclk, ser_sync, ser_data;
  logic [2:0]  fifo_level;
  logic        overflow, underflow;

  pcm_serializer #(
    .SAMPLE_BITS(16),
    .FIFO_DEPTH (4),
    .BCLK_DIV   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clr_flags (clr_flags),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .ser_bclk  (ser_bclk),
    .ser_sync  (ser_sync),
    .ser_data  (ser_data),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Receiver model: samples ser_data on every ser_bclk rise, frames start on ser_sync.
  logic [15:0] rx_q[$];
  logic [15:0] cur = '0;
  logic        bclk_prev = 1'b0;
  logic        in_frame = 1'b0;
  int nbits = 0, stray = 0, sync_err = 0, max_level = 0;
  int cyc = 0, t_first = -1, t_last = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rx_q.delete();
      in_frame = 1'b0; nbits = 0; stray = 0; sync_err = 0; max_level = 0;
      t_first = -1; t_last = 0; bclk_prev = 1'b0;
    end else begin
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (ser_bclk && !bclk_prev) begin
        if (ser_sync) begin
          if (in_frame) sync_err++;
          in_frame = 1'b1; nbits = 0; cur = '0;
          if (t_first < 0) t_first = cyc;
        end
        if (in_frame) begin
          cur = {cur[14:0], ser_data};
          nbits++;
          if (nbits == 16) begin
            rx_q.push_back(cur);
            t_last = cyc; in_frame = 1'b0; nbits = 0;
          end
        end else begin
          stray++;
        end
      end
      bclk_prev = ser_bclk;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 16'hxxxx;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; clr_flags = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    @(negedge clk);
    in_valid = 1'b1; in_sample = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string name);
    int i = 0;
    while (rx_q.size() < n && i < n * 64 + 200) begin
      @(posedge clk); #1; i++;
    end
    if (rx_q.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout, got %0d frames, expected %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic wait_bits(input int n, input string name);
    int i = 0;
    while (!(in_frame && nbits >= n) && i < 200) begin
      @(posedge clk); #1; i++;
    end
    if (!(in_frame && nbits >= n)) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout waiting for bit %0d", name, n);
    end
  endtask

  task automatic check_idle(input string name);
    int highs = 0;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ser_bclk || ser_sync || ser_data) highs++;
    end
    check(name, highs, 0);
  endtask

  typedef struct {
    logic [15:0] sample;
    logic [15:0] exp_rx;
  } vec_t;
  vec_t burst[4];

  logic [15:0] ovf_words[6];
  logic [15:0] fp_words[6];

  initial begin
    burst[0] = '{sample: 16'h8001, exp_rx: 16'h8001};
    burst[1] = '{sample: 16'h7FFE, exp_rx: 16'h7FFE};
    burst[2] = '{sample: 16'h0F0F, exp_rx: 16'h0F0F};
    burst[3] = '{sample: 16'hC3A5, exp_rx: 16'hC3A5};
    ovf_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    fp_words  = '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h5555, 16'hAAAA};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_bclk", ser_bclk, 0);
    check("rst_sync", ser_sync, 0);
    check("rst_data", ser_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ufl", underflow, 0);
    rst = 1'b0;

    // Single word, then one zero frame with underflow
    do_reset();
    enable = 1'b1;
    push(16'hA5C3);
    @(posedge clk); #1;
    check("sw_latency_data", ser_data, 1);
    check("sw_latency_sync", ser_sync, 1);
    check("sw_latency_level", fifo_level, 0);
    wait_rx(1, "sw_frame");
    check("sw_word", rx_at(0), 16'hA5C3);
    check("sw_ufl_before_end", underflow, 0);
    wait_rx(2, "sw_zero_frame");
    check("sw_zero_word", rx_at(1), 16'h0000);
    check("sw_ufl", underflow, 1);
    check("sw_sync_err", sync_err, 0);
    enable = 1'b0;
    check_idle("sw_idle");

    // Table-driven burst: one push per 32 clk
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(burst[i].sample);
      repeat (30) @(negedge clk);
    end
    wait_rx(4, "burst_frames");
    check("burst_ufl", underflow, 0);
    check("burst_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) check($sformatf("burst_word%0d", i), rx_at(i), burst[i].exp_rx);
    check("burst_span", t_last - t_first, 252);
    check("burst_stray", stray, 0);
    check("burst_sync_err", sync_err, 0);
    check("burst_peak", max_level, 2);
    enable = 1'b0;
    check_idle("burst_idle");

    // Overflow while idle, set beats clear, then ordered playback
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_sample = ovf_words[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_bclk_idle", ser_bclk, 0);
    clr_flags = 1'b1; in_valid = 1'b1; in_sample = 16'hDEAD;
    @(negedge clk);
    clr_flags = 1'b0; in_valid = 1'b0;
    check("ovf_set_wins", overflow, 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("ovf_cleared", overflow, 0);
    enable = 1'b1;
    wait_rx(4, "ovf_frames");
    for (int i = 0; i < 4; i++) check($sformatf("ovf_word%0d", i), rx_at(i), ovf_words[i]);
    enable = 1'b0;
    check_idle("ovf_idle");

    // enable dropped mid-frame
    do_reset();
    enable = 1'b1;
    push(16'h3C5A);
    push(16'hF00F);
    wait_bits(5, "drop_bit5");
    @(negedge clk);
    enable = 1'b0;
    wait_rx(1, "drop_frame");
    check("drop_word", rx_at(0), 16'h3C5A);
    check_idle("drop_idle");
    check("drop_frames", rx_q.size(), 1);
    check("drop_level", fifo_level, 1);
    enable = 1'b1;
    wait_rx(2, "drop_resume");
    check("drop_word2", rx_at(1), 16'hF00F);
    enable = 1'b0;
    check_idle("drop_idle2");

    // Push into a full FIFO on the frame-end pop cycle
    do_reset();
    for (int i = 0; i < 4; i++) push(fp_words[i]);
    @(negedge clk);
    enable = 1'b1;                 // next edge L pops word 0
    @(negedge clk);
    in_valid = 1'b1; in_sample = fp_words[4];
    @(negedge clk);                // word 4 written at L+1
    in_valid = 1'b0;
    check("fp_full_level", fifo_level, 4);
    repeat (62) @(negedge clk);
    in_valid = 1'b1; in_sample = fp_words[5];
    @(negedge clk);                // sampled at L+64 together with the frame-end pop
    in_valid = 1'b0;
    check("fp_ovf", overflow, 0);
    check("fp_level", fifo_level, 4);
    wait_rx(6, "fp_frames");
    for (int i = 0; i < 6; i++) check($sformatf("fp_word%0d", i), rx_at(i), fp_words[i]);
    check("fp_ovf_end", overflow, 0);
    enable = 1'b0;
    check_idle("fp_idle");

    // Asynchronous reset mid-frame
    do_reset();
    for (int i = 0; i < 5; i++) push(16'hFFFF);
    enable = 1'b1;
    wait_bits(3, "rst_mid_bits");
    check("pre_rst_ovf", overflow, 1);
    check("pre_rst_data", ser_data, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_data", ser_data, 0);
    check("mid_rst_sync", ser_sync, 0);
    check("mid_rst_bclk", ser_bclk, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;

    // clr_flags clears both flags
    enable = 1'b1;
    push(16'h1234);
    wait_rx(2, "clr_frames");
    enable = 1'b0;
    check_idle("clr_idle");
    for (int i = 0; i < 5; i++) push(16'h4321);
    check("clr_pre_ufl", underflow, 1);
    check("clr_pre_ovf", overflow, 1);
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("clr_ufl", underflow, 0);
    check("clr_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
